debouncer: RTL

DEBOUNCER -- requirements
Module: debouncer

---
 rtl/debounce_pkg.sv | 16 +
 rtl/sync_2ff.sv | 21 ++
 rtl/debouncer.sv | 108 ++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the debouncer: state encoding and a wait-state helper.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  // A candidate level change is being qualified only in the two wait states.
  function automatic logic is_wait(input state_t s);
    return (s == WAIT_HI) || (s == WAIT_LO);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous input into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/debouncer.sv
// Counter-based switch debouncer; define DEBOUNCER_SYNC_EN to insert a 2-flop
// synchronizer on noisy_in (adds two clocks of latency).
module debouncer
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 1000000,
  parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             noisy_in,
  output logic             db_level,
  output logic             busy,
  output state_t           dbg_state,
  output logic [CNT_W-1:0] dbg_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             s_in;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             level_n;

`ifdef DEBOUNCER_SYNC_EN
  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (noisy_in),
    .q     (s_in)
  );
`else
  assign s_in = noisy_in;
`endif

  // cnt holds the number of consecutive samples seen at the candidate level.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    level_n = db_level;
    case (state)
      IDLE_LO: begin
        if (s_in) begin
          state_n = WAIT_HI;
          cnt_n   = CNT_ONE;
        end else begin
          cnt_n = '0;
        end
      end
      WAIT_HI: begin
        if (!s_in) begin
          state_n = IDLE_LO;
          cnt_n   = '0;
        end else if (cnt == CNT_MAX) begin
          state_n = IDLE_HI;
          level_n = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      IDLE_HI: begin
        if (!s_in) begin
          state_n = WAIT_LO;
          cnt_n   = CNT_ONE;
        end else begin
          cnt_n = '0;
        end
      end
      WAIT_LO: begin
        if (s_in) begin
          state_n = IDLE_HI;
          cnt_n   = '0;
        end else if (cnt == CNT_MAX) begin
          state_n = IDLE_LO;
          level_n = 1'b0;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        state_n = IDLE_LO;
        cnt_n   = '0;
        level_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE_LO;
      cnt      <= '0;
      db_level <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      db_level <= level_n;
      busy     <= is_wait(state_n);
    end
  end

  assign dbg_state = state;
  assign dbg_cnt   = cnt;

endmodule
